// File: rtl/alu_seq_controller.sv
// ALU operation decoder plus sequential M-extension unit (shift-add multiply, restoring divide).
// Define ALU_SEQ_DIV_EN to build the divider; without it every divide/remainder op is flagged Illegal.
module alu_seq_controller #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            Start,
    input  logic            Kill,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic [3:0]      Operation,
    output logic            MClass,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result,
    output logic            Illegal
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned PW = 2 * XLEN;

`ifdef ALU_SEQ_DIV_EN
    typedef enum logic [1:0] {IDLE = 2'b00, MUL = 2'b01, DIV = 2'b10, DONE = 2'b11} state_t;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
`else
    typedef enum logic [1:0] {IDLE = 2'b00, MUL = 2'b01, DONE = 2'b11} state_t;
`endif

    state_t          r_state, w_state_n;
    logic [PW-1:0]   r_acc, w_acc_n;
    logic [XLEN-1:0] r_opb, w_opb_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic [1:0]      r_f3, w_f3_n;
    logic            r_neg, w_neg_n;
    logic [XLEN-1:0] r_result, w_result_n;
    logic            r_busy, r_done, w_done_n, r_illegal, w_illegal_n;

    logic            w_mclass;
    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic [XLEN:0]   w_sum;
    logic [PW-1:0]   w_mul_next, w_mul_prod;
    logic [XLEN-1:0] w_mul_res;

    assign w_mclass = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
    assign MClass   = w_mclass;

    // Single-cycle ALU select
    always_comb begin
        Operation = 4'b0000;
        case (ALUOp)
            2'b00: Operation = 4'b0010;
            2'b01: Operation = 4'b1000;
            2'b10: begin
                if (!w_mclass) begin
                    case (Funct3)
                        3'b000: Operation = (Funct7 == 7'b0100000) ? 4'b0011 : 4'b0010;
                        3'b001: Operation = 4'b0100;
                        3'b010: Operation = 4'b1100;
                        3'b101: begin
                            if (Funct7 == 7'b0000000)      Operation = 4'b0101;
                            else if (Funct7 == 7'b0100000) Operation = 4'b0111;
                        end
                        3'b110: Operation = 4'b0001;
                        default: Operation = 4'b0000;
                    endcase
                end
            end
            default: Operation = 4'b0000;
        endcase
    end

    // Operand signedness and magnitudes for the op being launched
    assign w_a_signed = Funct3[2] ? !Funct3[0] : (Funct3[1:0] != 2'b11);
    assign w_b_signed = Funct3[2] ? !Funct3[0] : !Funct3[1];
    assign w_a_neg    = w_a_signed & SrcA[XLEN-1];
    assign w_b_neg    = w_b_signed & SrcB[XLEN-1];
    assign w_a_mag    = w_a_neg ? (XLEN'(0) - SrcA) : SrcA;
    assign w_b_mag    = w_b_neg ? (XLEN'(0) - SrcB) : SrcB;
    assign w_neg      = (Funct3[2] & Funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    // Shift-add step: multiplier in the low half of r_acc, multiplicand in r_opb
    assign w_sum      = {1'b0, r_acc[PW-1:XLEN]} + {1'b0, r_opb};
    assign w_mul_next = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[PW-1:1]};
    assign w_mul_prod = r_neg ? (PW'(0) - w_mul_next) : w_mul_next;
    assign w_mul_res  = (r_f3 == 2'b00) ? w_mul_prod[XLEN-1:0] : w_mul_prod[PW-1:XLEN];

`ifdef ALU_SEQ_DIV_EN
    logic [XLEN:0]   w_shift, w_diff;
    logic            w_ge;
    logic [PW-1:0]   w_div_next;
    logic [XLEN-1:0] w_div_pick, w_div_res;

    // Restoring step: remainder in the high half, dividend/quotient in the low half
    assign w_shift    = r_acc[PW-1:XLEN-1];
    assign w_diff     = w_shift - {1'b0, r_opb};
    assign w_ge       = (w_shift >= {1'b0, r_opb});
    assign w_div_next = w_ge ? {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                             : {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    assign w_div_pick = r_f3[1] ? w_div_next[PW-1:XLEN] : w_div_next[XLEN-1:0];
    assign w_div_res  = r_neg ? (XLEN'(0) - w_div_pick) : w_div_pick;
`endif

    always_comb begin
        w_state_n   = r_state;
        w_acc_n     = r_acc;
        w_opb_n     = r_opb;
        w_cnt_n     = r_cnt;
        w_f3_n      = r_f3;
        w_neg_n     = r_neg;
        w_result_n  = r_result;
        w_done_n    = 1'b0;
        w_illegal_n = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start && w_mclass && !Kill) begin
                    w_f3_n  = Funct3[1:0];
                    w_neg_n = w_neg;
                    w_cnt_n = '0;
                    if (!Funct3[2]) begin
                        w_state_n = MUL;
                        w_acc_n   = {XLEN'(0), w_b_mag};
                        w_opb_n   = w_a_mag;
                    end
`ifdef ALU_SEQ_DIV_EN
                    else if (SrcB == '0) begin
                        w_result_n = Funct3[1] ? SrcA : '1;
                        w_done_n   = 1'b1;
                        w_state_n  = DONE;
                    end else if (!Funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1)) begin
                        w_result_n = Funct3[1] ? '0 : SrcA;
                        w_done_n   = 1'b1;
                        w_state_n  = DONE;
                    end else begin
                        w_state_n = DIV;
                        w_acc_n   = {XLEN'(0), w_a_mag};
                        w_opb_n   = w_b_mag;
                    end
`else
                    else begin
                        w_result_n  = '0;
                        w_done_n    = 1'b1;
                        w_illegal_n = 1'b1;
                        w_state_n   = DONE;
                    end
`endif
                end
            end
            MUL: begin
                if (Kill) begin
                    w_state_n = IDLE;
                end else begin
                    w_acc_n = w_mul_next;
                    w_cnt_n = r_cnt + CW'(1);
                    if (r_cnt == CW'(XLEN - 1)) begin
                        w_result_n = w_mul_res;
                        w_done_n   = 1'b1;
                        w_state_n  = DONE;
                    end
                end
            end
`ifdef ALU_SEQ_DIV_EN
            DIV: begin
                if (Kill) begin
                    w_state_n = IDLE;
                end else begin
                    w_acc_n = w_div_next;
                    w_cnt_n = r_cnt + CW'(1);
                    if (r_cnt == CW'(XLEN - 1)) begin
                        w_result_n = w_div_res;
                        w_done_n   = 1'b1;
                        w_state_n  = DONE;
                    end
                end
            end
`endif
            DONE:    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_opb     <= '0;
            r_cnt     <= '0;
            r_f3      <= '0;
            r_neg     <= 1'b0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_acc     <= w_acc_n;
            r_opb     <= w_opb_n;
            r_cnt     <= w_cnt_n;
            r_f3      <= w_f3_n;
            r_neg     <= w_neg_n;
            r_result  <= w_result_n;
            r_busy    <= (w_state_n != IDLE);
            r_done    <= w_done_n;
            r_illegal <= w_illegal_n;
        end
    end

    assign Busy    = r_busy;
    assign Done    = r_done;
    assign Result  = r_result;
    assign Illegal = r_illegal;

endmodule
